multi_button_input: RTL and testbench

MULTI_BUTTON_INPUT -- requirements
Module: multi_button_input

---
 rtl/multi_button_input.sv | 128 ++++++++++++
 tb/tb_multi_button_input.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_button_input.sv
// Per-channel button front end: synchronizer, debounce filter,
// press/release edge pulses and an auto-repeat event generator.
module multi_button_input #(
  parameter int N_CH       = 4,
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_event
);

  localparam int DBW  = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ?
                        RPT_DELAY : RPT_PERIOD;
  localparam int HW   = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]  DLY_LAST = HW'(RPT_DELAY - 1);
  localparam logic [HW-1:0]  PER_LAST = HW'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FIRST,
    REPEAT
  } rpt_state_e;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic           s1_q, s2_q;
    logic [DBW-1:0] db_q, db_d;
    logic           lvl_q, lvl_d;
    logic           prs_q, prs_d;
    logic           rel_q, rel_d;
    logic           evt_q, evt_d;
    logic [HW-1:0]  hold_q, hold_d;
    rpt_state_e     st_q, st_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        db_q   <= '0;
        lvl_q  <= 1'b0;
        prs_q  <= 1'b0;
        rel_q  <= 1'b0;
        evt_q  <= 1'b0;
        hold_q <= '0;
        st_q   <= IDLE;
      end else begin
        s1_q   <= btn_in[g];
        s2_q   <= s1_q;
        db_q   <= db_d;
        lvl_q  <= lvl_d;
        prs_q  <= prs_d;
        rel_q  <= rel_d;
        evt_q  <= evt_d;
        hold_q <= hold_d;
        st_q   <= st_d;
      end
    end

    // Edge pulses are taken from the level flip itself so they
    // register on the same edge that the new level appears.
    always_comb begin
      db_d  = '0;
      lvl_d = lvl_q;
      if (s2_q != lvl_q) begin
        if (db_q == DB_LAST) begin
          lvl_d = ~lvl_q;
        end else begin
          db_d = db_q + DBW'(1);
        end
      end
      prs_d = lvl_d & ~lvl_q;
      rel_d = ~lvl_d & lvl_q;
    end

    // Release outranks a repeat tick due on the same edge.
    always_comb begin
      st_d   = st_q;
      hold_d = hold_q;
      evt_d  = 1'b0;
      if (rel_d) begin
        st_d   = IDLE;
        hold_d = '0;
      end else if (prs_d) begin
        st_d   = WAIT_FIRST;
        hold_d = '0;
        evt_d  = 1'b1;
      end else if (rpt_en[g]) begin
        case (st_q)
          WAIT_FIRST: begin
            if (hold_q == DLY_LAST) begin
              st_d   = REPEAT;
              hold_d = '0;
              evt_d  = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          REPEAT: begin
            if (hold_q == PER_LAST) begin
              hold_d = '0;
              evt_d  = 1'b1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          default: begin
            st_d = IDLE;
          end
        endcase
      end
    end

    assign btn_level[g]   = lvl_q;
    assign btn_press[g]   = prs_q;
    assign btn_release[g] = rel_q;
    assign btn_event[g]   = evt_q;
  end

endmodule

// File: tb/tb_multi_button_input.sv
// Bench for multi_button_input: expected pulses are queued with
// their cycle stamps and matched by a negedge monitor.
module tb_multi_button_input;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] rpt_en = 4'hF;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_event;

  multi_button_input #(
    .N_CH(4),
    .DB_CYCLES(4),
    .RPT_DELAY(10),
    .RPT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .rpt_en(rpt_en),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_event(btn_event)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic string kname(int k);
    if (k == 0) return "press";
    if (k == 1) return "release";
    return "event";
  endfunction

  task automatic push(int ch, int kind, int c);
    exp_t e;
    e.cyc = c;
    e.ch = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h",
               name, act, req);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic v;
    int idx;
    for (int ch = 0; ch < 4; ch++) begin
      for (int k = 0; k < 3; k++) begin
        v = (k == 0) ? btn_press[ch] :
            (k == 1) ? btn_release[ch] : btn_event[ch];
        if (v) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].ch == ch && sb[i].kind == k)
              idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected %s ch%0d at cycle %0d",
                     kname(k), ch, cyc);
          end else begin
            if (sb[idx].cyc != cyc) begin
              errors++;
              $display("FAIL %s ch%0d cycle actual %0d required %0d",
                       kname(k), ch, cyc, sb[idx].cyc);
            end
            sb.delete(idx);
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed %s ch%0d actual none required %0d",
                 kname(sb[i].kind), sb[i].ch, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    int k, t, r;
    step(3);
    chk("reset_level", 32'(btn_level), 0);
    chk("reset_press", 32'(btn_press), 0);
    chk("reset_event", 32'(btn_event), 0);
    rst = 1'b0;

    // ch0: press, repeats, release lands on a repeat tick
    step(1);
    k = cyc;
    t = k + 6;
    btn_in[0] = 1'b1;
    push(0, 0, t);
    push(0, 2, t);
    push(0, 2, t + 10);
    push(0, 2, t + 13);
    push(0, 2, t + 16);
    push(0, 2, t + 19);
    push(0, 2, t + 22);
    push(0, 1, t + 25);
    step(7);
    chk("a_level_high", 32'(btn_level[0]), 1);
    step(18);
    btn_in[0] = 1'b0;
    step(15);
    chk("a_level_low", 32'(btn_level[0]), 0);

    // ch1: 3-cycle glitch
    step(1);
    btn_in[1] = 1'b1;
    step(3);
    btn_in[1] = 1'b0;
    step(4);
    chk("b_level_mid", 32'(btn_level[1]), 0);
    step(6);
    chk("b_level_end", 32'(btn_level[1]), 0);

    // ch2: repeat disabled, enabled 20 cycles after press
    step(1);
    k = cyc;
    t = k + 6;
    rpt_en[2] = 1'b0;
    btn_in[2] = 1'b1;
    push(2, 0, t);
    push(2, 2, t);
    push(2, 2, t + 30);
    push(2, 2, t + 33);
    push(2, 2, t + 36);
    push(2, 2, t + 39);
    push(2, 2, t + 42);
    push(2, 1, t + 43);
    step(26);
    chk("c_level_held", 32'(btn_level[2]), 1);
    rpt_en[2] = 1'b1;
    step(17);
    btn_in[2] = 1'b0;
    step(12);
    chk("c_level_low", 32'(btn_level[2]), 0);

    // ch3: short hold, release on the first-repeat edge
    step(1);
    k = cyc;
    btn_in[3] = 1'b1;
    push(3, 0, k + 6);
    push(3, 2, k + 6);
    push(3, 1, k + 16);
    step(8);
    chk("d_level_high", 32'(btn_level[3]), 1);
    step(2);
    btn_in[3] = 1'b0;
    step(12);
    chk("d_level_low", 32'(btn_level[3]), 0);

    // ch0: reset mid-repeat, then re-debounce from zero
    step(1);
    k = cyc;
    t = k + 6;
    btn_in[0] = 1'b1;
    push(0, 0, t);
    push(0, 2, t);
    push(0, 2, t + 10);
    push(0, 2, t + 13);
    step(20);
    rst = 1'b1;
    #1;
    chk("e_rst_level", 32'(btn_level), 0);
    chk("e_rst_event", 32'(btn_event), 0);
    step(3);
    chk("e_rst_level2", 32'(btn_level), 0);
    chk("e_rst_rel", 32'(btn_release), 0);
    rst = 1'b0;
    r = cyc;
    push(0, 0, r + 6);
    push(0, 2, r + 6);
    push(0, 2, r + 16);
    push(0, 2, r + 19);
    push(0, 2, r + 22);
    push(0, 1, r + 23);
    step(5);
    chk("e_level_pre", 32'(btn_level[0]), 0);
    step(1);
    chk("e_level_post", 32'(btn_level[0]), 1);
    step(11);
    btn_in[0] = 1'b0;
    step(15);

    // all channels on the same edge
    step(1);
    k = cyc;
    t = k + 6;
    btn_in = 4'hF;
    for (int ch = 0; ch < 4; ch++) begin
      push(ch, 0, t);
      push(ch, 2, t);
      push(ch, 2, t + 10);
      push(ch, 2, t + 13);
      push(ch, 2, t + 16);
      push(ch, 2, t + 19);
      push(ch, 1, t + 20);
    end
    step(7);
    chk("f_level_all", 32'(btn_level), 32'hF);
    step(13);
    btn_in = 4'h0;
    step(15);
    chk("f_level_none", 32'(btn_level), 0);

    step(5);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
